// File: rtl/ps2_receiver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_receiver_pkg
// Description : Shared PS/2 definitions: frame size, FSM state encoding,
//               default filter/timeout settings and the odd-parity helper.
//               Intended to also serve the host-to-device transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_receiver_pkg;

  localparam int PS2_FRAME_BITS         = 11;
  localparam int PS2_DATA_BITS          = 8;
  localparam int DEFAULT_FILTER_LEN     = 8;
  localparam int DEFAULT_TIMEOUT_CYCLES = 50000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_t;

  // Odd parity over data plus parity bit: an odd number of ones is good.
  function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] d,
                                         input logic                     p);
    return ^{d, p};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_receiver_sync_filter.sv
`default_nettype none
// ============================================================================
// Module      : ps2_receiver_sync_filter
// Description : Two-flop synchronizer, run-length glitch filter and
//               registered falling-edge pulse for one PS/2 pad line.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_receiver_sync_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic filt,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] run_cnt;

  // Synchronize, then flip the filtered level only after FILTER_LEN
  // consecutive samples disagree with it; a 1->0 flip emits a fall pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      filt    <= 1'b1;
      run_cnt <= '0;
      fall    <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      fall  <= 1'b0;
      if (sync2 == filt) begin
        run_cnt <= '0;
      end else if (run_cnt == CW'(FILTER_LEN - 1)) begin
        filt    <= sync2;
        run_cnt <= '0;
        fall    <= filt;
      end else begin
        run_cnt <= run_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ps2_receiver.sv
`default_nettype none
// ============================================================================
// Module      : ps2_receiver
// Description : Host-side PS/2 device-to-host frame receiver. Decodes start,
//               8 data bits LSB first, odd parity and stop; strobes good
//               bytes, parity errors, and framing/timeout errors.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_receiver
  import ps2_receiver_pkg::*;
#(
  parameter int FILTER_LEN     = DEFAULT_FILTER_LEN,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic       qzt_clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic          clk_fall;
  logic          clk_level_unused;
  logic          data_filt;
  logic          data_fall_unused;

  ps2_state_t    state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par;
  logic [TW-1:0] tmo_cnt;

  ps2_receiver_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk  (qzt_clk),
    .rst  (reset),
    .raw  (ps2c_in),
    .filt (clk_level_unused),
    .fall (clk_fall)
  );

  ps2_receiver_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk  (qzt_clk),
    .rst  (reset),
    .raw  (ps2d_in),
    .filt (data_filt),
    .fall (data_fall_unused)
  );

  // Frame FSM, shift register, inter-edge timeout and registered outputs.
  always_ff @(posedge qzt_clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      bit_cnt    <= '0;
      shreg      <= '0;
      par        <= 1'b0;
      tmo_cnt    <= '0;
      data       <= 8'h00;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      if (!enable) begin
        // Host owns the bus: drop any partial frame silently.
        state   <= ST_IDLE;
        busy    <= 1'b0;
        tmo_cnt <= '0;
      end else if (clk_fall) begin
        tmo_cnt <= '0;
        case (state)
          ST_IDLE: begin
            if (!data_filt) begin
              state   <= ST_SHIFT;
              busy    <= 1'b1;
              bit_cnt <= '0;
            end
          end
          ST_SHIFT: begin
            shreg   <= {data_filt, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= ST_PARITY;
          end
          ST_PARITY: begin
            par   <= data_filt;
            state <= ST_STOP;
          end
          ST_STOP: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            if (!data_filt) begin
              frame_err <= 1'b1;
            end else if (odd_parity_ok(shreg, par)) begin
              data       <= shreg;
              data_valid <= 1'b1;
            end else begin
              parity_err <= 1'b1;
            end
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end else if (state != ST_IDLE) begin
        // Device stopped clocking mid-frame.
        if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          frame_err <= 1'b1;
          state     <= ST_IDLE;
          busy      <= 1'b0;
          tmo_cnt   <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end else begin
        tmo_cnt <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_receiver
// Description : Self-checking bench for ps2_receiver. Drives PS/2 frames at a
//               shortened bit rate and compares strobes/data/busy against a
//               frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_receiver;

  localparam int HALF    = 50;    // PS/2 half period in qzt_clk cycles
  localparam int TIMEOUT = 1000;  // shortened inter-edge timeout
  localparam int FILT    = 8;
  // Cycles from a raw pad fall to the registered fall pulse edge:
  // two synchronizer stages, FILT filter samples, one pulse register.
  localparam int EDGE_LAT = 2 + FILT + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic       ps2c = 1'b1;
  logic       ps2d = 1'b1;
  logic [7:0] data;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;
  int n_dv = 0, n_pe = 0, n_fe = 0;
  int s_dv, s_pe, s_fe;
  logic [7:0] model_data = 8'h00;

  ps2_receiver #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .qzt_clk    (clk),
    .reset      (reset),
    .enable     (enable),
    .ps2c_in    (ps2c),
    .ps2d_in    (ps2d),
    .data       (data),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Count strobe-high cycles; a strobe wider than one cycle shows as extra counts.
  always @(negedge clk) begin
    if (data_valid) n_dv++;
    if (parity_err) n_pe++;
    if (frame_err)  n_fe++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    s_dv = n_dv; s_pe = n_pe; s_fe = n_fe;
  endtask

  // One bit cell: data changes mid-high, then a full low phase, then high.
  task automatic send_bit(input logic b, input bit glitch);
    ps2d = b;
    tick(HALF / 2);
    ps2c = 1'b0;
    if (glitch) begin
      tick(HALF / 2);
      ps2c = 1'b1;
      tick(3);
      ps2c = 1'b0;
      tick(HALF - HALF / 2 - 3);
    end else begin
      tick(HALF);
    end
    ps2c = 1'b1;
    tick(HALF - HALF / 2);
  endtask

  function automatic logic good_parity(input logic [7:0] b);
    return ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
  endfunction

  // Send one full frame and compare the outcome with the frame-level model.
  task automatic run_frame(input logic [7:0] b, input logic p, input logic stop,
                           input int glitch_bit);
    logic [10:0] bits;
    bit ones_odd;
    int e_dv, e_pe, e_fe;
    bits = {stop, p, b, 1'b0};
    snap();
    for (int i = 0; i < 11; i++) send_bit(bits[i], glitch_bit == i);
    tick(HALF);
    ones_odd = (($countones(b) + int'(p)) % 2) == 1;
    e_fe = stop ? 0 : 1;
    e_dv = (stop && ones_odd) ? 1 : 0;
    e_pe = (stop && !ones_odd) ? 1 : 0;
    if (e_dv == 1) model_data = b;
    check("frame_data_valid", n_dv - s_dv, e_dv);
    check("frame_parity_err", n_pe - s_pe, e_pe);
    check("frame_frame_err",  n_fe - s_fe, e_fe);
    check("frame_data",       data, model_data);
    check("frame_busy_after", busy, 1'b0);
  endtask

  initial begin
    logic [7:0] rb;
    logic       rp;
    logic       rs;
    int         gb;
    int         n;
    bit         seen;

    // Reset values
    tick(5);
    check("rst_data", data, 8'h00);
    check("rst_dv",   data_valid, 1'b0);
    check("rst_pe",   parity_err, 1'b0);
    check("rst_fe",   frame_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    reset = 1'b0;
    tick(HALF);

    // Good frame, back-to-back frames, parity error, stop error
    run_frame(8'h1C, 1'b0, 1'b1, -1);
    run_frame(8'hF0, 1'b1, 1'b1, -1);
    run_frame(8'h1C, 1'b0, 1'b1, -1);
    run_frame(8'h1C, 1'b1, 1'b1, -1);
    run_frame(8'hAA, 1'b1, 1'b0, -1);

    // Partial frame then a stalled clock: timeout framing error
    snap();
    for (int i = 0; i < 4; i++) send_bit((i == 0) ? 1'b0 : 1'b1, 1'b0);
    ps2d = 1'b0;
    tick(HALF / 2);
    ps2c = 1'b0;
    n = 0;
    seen = 1'b0;
    while (n < TIMEOUT + 200 && !seen) begin
      @(posedge clk); #1;
      n++;
      if (n == HALF) ps2c = 1'b1;
      if (frame_err) seen = 1'b1;
    end
    check("timeout_seen", seen, 1'b1);
    check("timeout_latency", n, EDGE_LAT + TIMEOUT);
    ps2c = 1'b1;
    tick(HALF);
    check("timeout_busy", busy, 1'b0);
    check("timeout_fe_count", n_fe - s_fe, 1);
    check("timeout_dv_count", n_dv - s_dv, 0);
    run_frame(8'hAA, 1'b1, 1'b1, -1);

    // Idle low glitch on the clock line
    snap();
    ps2c = 1'b0;
    tick(3);
    ps2c = 1'b1;
    tick(30);
    check("idle_glitch_busy", busy, 1'b0);
    check("idle_glitch_strobes", (n_dv - s_dv) + (n_pe - s_pe) + (n_fe - s_fe), 0);

    // Mid-frame high glitch in a low phase
    run_frame(8'h3B, good_parity(8'h3B), 1'b1, 5);

    // Abort with enable low
    snap();
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
    check("abort_en_busy_mid", busy, 1'b1);
    enable = 1'b0;
    tick(10);
    enable = 1'b1;
    tick(HALF);
    check("abort_en_busy", busy, 1'b0);
    check("abort_en_strobes", (n_dv - s_dv) + (n_pe - s_pe) + (n_fe - s_fe), 0);
    check("abort_en_data", data, model_data);
    run_frame(8'h55, 1'b1, 1'b1, -1);

    // Abort with a one-cycle reset
    snap();
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    model_data = 8'h00;
    tick(HALF);
    check("abort_rst_busy", busy, 1'b0);
    check("abort_rst_data", data, 8'h00);
    check("abort_rst_strobes", (n_dv - s_dv) + (n_pe - s_pe) + (n_fe - s_fe), 0);
    run_frame(8'h55, 1'b1, 1'b1, -1);

    // Randomized frames: random byte, occasional bad parity/stop, random glitch
    for (int k = 0; k < 12; k++) begin
      rb = 8'($urandom);
      rp = good_parity(rb) ^ (($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
      rs = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
      gb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 10)) : -1;
      run_frame(rb, rp, rs, gb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
